shared_reg_rr_arbiter: RTL and testbench

//  Round-robin write arbiter for one shared W-bit storage register built from async-reset D flip-flops.
//  Up to N requesters offer write data. The block grants exactly one per cycle and captures the winner's data.
//  It returns a one-hot grant that also serves as the write acknowledge.

---
 rtl/shared_reg_pkg.sv | 31 +++
 rtl/rr_priority_pick.sv | 38 +++
 rtl/shared_reg_rr_arbiter.sv | 114 +++++++++++
 tb/tb_shared_reg_rr_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/shared_reg_pkg.sv
// -----------------------------------------------------------------------------
// shared_reg_pkg
//  Shared types and constants for the round-robin shared-register arbiter.
//  Contents: FSM state encoding, default N/W, one-hot helper.
//  Optional feature macro used by the arbiter: SHARED_REG_LOCK_EN.
// -----------------------------------------------------------------------------
package shared_reg_pkg;

    localparam int unsigned N_DEF   = 4;
    localparam int unsigned W_DEF   = 8;
    localparam int unsigned N_MAX   = 16;
    localparam int unsigned IDX_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_LOCK  = 2'd2
    } state_e;

    // One-hot vector with bit idx set; bits at or above n are forced to zero.
    function automatic logic [N_MAX-1:0] onehot(input logic [IDX_W-1:0] idx,
                                                 input int unsigned      n);
        logic [N_MAX-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < N_MAX; i++) begin
            v[i] = (IDX_W'(i) == idx) && (i < n);
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
//  Combinational round-robin pick: scans from ptr+1 upward modulo N and
//  returns the first requesting index.
//  Ports:
//    req     in  N   request vector
//    ptr     in  PW  index of the last granted requester
//    win     out PW  winning index (0 when no request)
//    any_req out 1   at least one request present
// -----------------------------------------------------------------------------
module rr_priority_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] win,
    output logic          any_req
);

    // Offsets 1..N cover every requester once, ending at ptr itself.
    always_comb begin
        logic        found;
        int unsigned idx;
        found   = 1'b0;
        idx     = 0;
        win     = '0;
        any_req = |req;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/shared_reg_rr_arbiter.sv
// -----------------------------------------------------------------------------
// shared_reg_rr_arbiter
//  Round-robin write arbiter for one shared W-bit register. One grant per
//  cycle; the grant doubles as the write acknowledge and appears in the same
//  cycle q shows the winner's data.
//  Optional macro SHARED_REG_LOCK_EN adds the lock port and LOCK state, which
//  lets the current grantee keep ownership while req and lock stay high.
//  Ports:
//    clk      in  1    rising-edge clock
//    reset_n  in  1    asynchronous active-low reset
//    req      in  N    per-requester write request
//    wdata    in  N*W  packed write words, requester i at [i*W +: W]
//    lock     in  N    hold request (SHARED_REG_LOCK_EN builds only)
//    gnt      out N    registered one-hot grant
//    q        out W    shared register contents
//    busy     out 1    registered, high whenever state is not IDLE
// -----------------------------------------------------------------------------
module shared_reg_rr_arbiter
    import shared_reg_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned W = W_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] wdata,
`ifdef SHARED_REG_LOCK_EN
    input  logic [N-1:0]   lock,
`endif
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   q,
    output logic           busy
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    state_e         state_q, state_d;
    logic [PW-1:0]  ptr_q,   ptr_d;
    logic [N-1:0]   gnt_q,   gnt_d;
    logic [W-1:0]   q_q,     q_d;
    logic           busy_q;

    logic [PW-1:0]  win;
    logic           any_req;
    logic           hold;
    logic [W-1:0]   words [N];

    rr_priority_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win     (win),
        .any_req (any_req)
    );

    // Unpack write words for indexed selection.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            words[i] = wdata[i*W +: W];
        end
    end

    // Current grantee is ptr_q whenever a grant is outstanding.
`ifdef SHARED_REG_LOCK_EN
    assign hold = (state_q != ST_IDLE) && req[ptr_q] && lock[ptr_q];
`else
    assign hold = 1'b0;
`endif

    // Next-state: lock hold, then round-robin grant, otherwise idle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        q_d     = q_q;
        if (hold) begin
            state_d = ST_LOCK;
            q_d     = words[ptr_q];
        end else if (any_req) begin
            state_d = ST_GRANT;
            ptr_d   = win;
            gnt_d   = N'(onehot(IDX_W'(win), N));
            q_d     = words[win];
        end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
        end
    end

    // Pointer resets to N-1 so requester 0 has first priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= PW'(N - 1);
            gnt_q   <= '0;
            q_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign gnt  = gnt_q;
    assign q    = q_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_shared_reg_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_reg_rr_arbiter
//  Self-checking bench for shared_reg_rr_arbiter with N=4, W=8: directed
//  scenarios followed by random traffic against a behavioural model.
//  Honours SHARED_REG_LOCK_EN when defined.
// -----------------------------------------------------------------------------
module tb_shared_reg_rr_arbiter;

    localparam int NN = 4;
    localparam int WW = 8;

    logic              clk;
    logic              reset_n;
    logic [NN-1:0]     req;
    logic [NN*WW-1:0]  wdata;
`ifdef SHARED_REG_LOCK_EN
    logic [NN-1:0]     lock;
`endif
    logic [NN-1:0]     gnt;
    logic [WW-1:0]     q;
    logic              busy;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model: last-grant index, outstanding grant, register value.
    int          m_ptr;
    logic [3:0]  m_gnt;
    logic [7:0]  m_q;
    logic        m_busy;

    shared_reg_rr_arbiter #(.N(NN), .W(WW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .wdata   (wdata),
`ifdef SHARED_REG_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .q       (q),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = NN - 1;
        m_gnt  = 4'b0000;
        m_q    = 8'h00;
        m_busy = 1'b0;
    endtask

    // One rising edge of the specified behaviour, from current inputs.
    task automatic model_edge();
        bit hold;
        bit found;
        int idx;
        hold  = 0;
        found = 0;
`ifdef SHARED_REG_LOCK_EN
        if (m_gnt != 0 && req[m_ptr] && lock[m_ptr]) hold = 1;
`endif
        if (hold) begin
            m_q    = wdata[m_ptr*WW +: WW];
            m_busy = 1'b1;
        end else if (req != 0) begin
            for (int k = 1; k <= NN; k++) begin
                idx = (m_ptr + k) % NN;
                if (!found && req[idx]) begin
                    found  = 1;
                    m_ptr  = idx;
                end
            end
            m_gnt  = 4'(1 << m_ptr);
            m_q    = wdata[m_ptr*WW +: WW];
            m_busy = 1'b1;
        end else begin
            m_gnt  = 4'b0000;
            m_busy = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".gnt"},  32'(gnt),  32'(m_gnt));
        chk({tag, ".q"},    32'(q),    32'(m_q));
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
    endtask

    initial begin
        logic [3:0] exp_seq [5];
        logic [7:0] wv;
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
`ifdef SHARED_REG_LOCK_EN
        lock = 4'b0000;
`endif

        // 1: reset with all requests high, no clock edge yet
        reset_n = 1'b0;
        req     = 4'b1111;
        wdata   = 32'h4433_2211;
        model_reset();
        #2;
        chk("rst.q",    32'(q),    32'h00);
        chk("rst.gnt",  32'(gnt),  32'h0);
        chk("rst.busy", 32'(busy), 32'h0);

        // 2: single write from requester 2
        #1;
        reset_n = 1'b1;
        req     = 4'b0100;
        wdata   = 32'h00A5_0000;
        step();
        chk("s2.gnt",  32'(gnt),  32'b0100);
        chk("s2.q",    32'(q),    32'hA5);
        chk("s2.busy", 32'(busy), 32'h1);
        req = 4'b0000;
        step();
        chk("s2.gnt0",  32'(gnt),  32'h0);
        chk("s2.qhold", 32'(q),    32'hA5);
        chk("s2.idle",  32'(busy), 32'h0);

        // 3: all requesting after reset rotates 0,1,2,3,0
        reset_n = 1'b0;
        model_reset();
        #1;
        reset_n = 1'b1;
        req     = 4'b1111;
        wdata   = 32'h4433_2211;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("s3.gnt%0d", i), 32'(gnt), 32'(exp_seq[i]));
            wv = 8'(8'h11 * (((i % 4)) + 1));
            chk($sformatf("s3.q%0d", i), 32'(q), 32'(wv));
        end

        // 4: last grant = 1, then 1010 held -> 3 then 1
        step();
        chk("s4.pre", 32'(gnt), 32'b0010);
        req = 4'b1010;
        step();
        chk("s4.g3", 32'(gnt), 32'b1000);
        chk("s4.q3", 32'(q),   32'h44);
        step();
        chk("s4.g1", 32'(gnt), 32'b0010);
        chk("s4.q1", 32'(q),   32'h22);

        // 5: async reset mid-cycle while requester 2 is granted
        req = 4'b0100;
        step();
        chk("s5.pre", 32'(gnt), 32'b0100);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("s5.gnt",  32'(gnt),  32'h0);
        chk("s5.q",    32'(q),    32'h00);
        chk("s5.busy", 32'(busy), 32'h0);
        #1;
        reset_n = 1'b1;
        req     = 4'b1111;
        step();
        chk("s5.first", 32'(gnt), 32'b0001);

`ifdef SHARED_REG_LOCK_EN
        // 6: lock held by requester 0 for three cycles, then released
        reset_n = 1'b0;
        model_reset();
        #1;
        reset_n = 1'b1;
        req     = 4'b0011;
        lock    = 4'b0001;
        wdata   = 32'h0000_2211;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("s6.hold%0d", i), 32'(gnt), 32'b0001);
            chk($sformatf("s6.busy%0d", i), 32'(busy), 32'h1);
            wdata[7:0] = 8'(8'h30 + i);
        end
        lock = 4'b0000;
        step();
        chk("s6.rel", 32'(gnt), 32'b0010);
        chk("s6.relq", 32'(q),  32'h22);
`endif

        // 7: random traffic against the model
        for (int i = 0; i < 300; i++) begin
            req   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req = 4'b0000;
            wdata = $urandom;
`ifdef SHARED_REG_LOCK_EN
            lock  = 4'($urandom_range(0, 15));
`endif
            if (i == 150) begin
                #2;
                reset_n = 1'b0;
                model_reset();
                #1;
                chk("rnd.rst", 32'(gnt), 32'h0);
                reset_n = 1'b1;
            end
            step();
            chk_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
